axi4_lite_cordic_master: RTL

//  AXI4-Lite initiator driving the CORDIC register slave. Takes one request (angle, mode) from a

---
 rtl/axi4_lite_cordic_master.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_cordic_master.sv
// axi4_lite_cordic_master
//
// Purpose:
//   AXI4-Lite initiator that runs one CORDIC operation per accepted request.
//   Sequence: write the angle to INPUT, write the start flags to FLAGS_IN,
//   poll FLAGS_OUT until the done bit is set, then read RESULT. The result
//   and an error code are returned on a valid/ready response port. Only one
//   operation is in flight at a time.
//
// Ports:
//   aclk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready          request handshake (ready only while idle)
//   req_theta, req_mode          signed angle and CORDIC mode bit
//   rsp_valid/rsp_ready          response handshake (valid held until ready)
//   rsp_result, rsp_err          RESULT data (0 on error); 00 ok, 01 bus error, 10 timeout
//   aw*, w*, b*, ar*, r*         AXI4-Lite master channels, 32-bit address/data
//
// Configuration:
//   CORDIC_MASTER_TIMEOUT_EN     when defined, an 11-bit poll counter aborts the
//                                operation with err=10 after TIMEOUT_POLLS polls
//                                that return done=0. Undefined: polling is unbounded.

module axi4_lite_cordic_master #(
    parameter logic [31:0] BASE_ADDR     = 32'hF000_0000,
    parameter int          POLL_GAP      = 4,
    parameter int          TIMEOUT_POLLS = 1024
) (
    input  logic        aclk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_theta,
    input  logic        req_mode,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [1:0]  rsp_err,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_IN   = 3'd1;
    localparam logic [2:0] S_WR_FLG  = 3'd2;
    localparam logic [2:0] S_RD_STAT = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;
    localparam logic [2:0] S_RD_RES  = 3'd5;
    localparam logic [2:0] S_RESP    = 3'd6;

    localparam logic [31:0] ADDR_INPUT     = BASE_ADDR + 32'h18;
    localparam logic [31:0] ADDR_RESULT    = BASE_ADDR + 32'h1C;
    localparam logic [31:0] ADDR_FLAGS_IN  = BASE_ADDR + 32'h20;
    localparam logic [31:0] ADDR_FLAGS_OUT = BASE_ADDR + 32'h24;

    localparam int GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;

    logic [2:0]  r_state;
    logic        r_mode;
    logic [31:0] r_awaddr;
    logic        r_awvalid;
    logic [31:0] r_wdata;
    logic        r_wvalid;
    logic        r_bready;
    logic        r_aw_done;
    logic        r_w_done;
    logic [31:0] r_araddr;
    logic        r_arvalid;
    logic        r_rready;
    logic [15:0] r_gap;
    logic        r_rsp_valid;
    logic [31:0] r_result;
    logic [1:0]  r_err;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_timeout;

    assign w_aw_hs = r_awvalid && awready;
    assign w_w_hs  = r_wvalid && wready;
    assign w_b_hs  = r_bready && bvalid;
    assign w_ar_hs = r_arvalid && arready;
    assign w_r_hs  = r_rready && rvalid;

`ifdef CORDIC_MASTER_TIMEOUT_EN
    localparam logic [10:0] POLL_LAST = 11'(TIMEOUT_POLLS - 1);
    logic [10:0] r_polls;

    // Counts completed polls that came back with done=0; the poll that would
    // reach TIMEOUT_POLLS aborts instead of scheduling another one.
    assign w_timeout = (r_polls == POLL_LAST);

    always_ff @(posedge aclk) begin
        if (rst) begin
            r_polls <= 11'd0;
        end else if (r_state == S_IDLE && req_valid) begin
            r_polls <= 11'd0;
        end else if (r_state == S_RD_STAT && w_r_hs && rresp == 2'b00
                     && !rdata[0] && !w_timeout) begin
            r_polls <= r_polls + 11'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Main sequencer. Each phase's first request (valid) is raised on the same
    // edge that enters the phase, so the bus sees it in the state's first cycle.
    // AW and W are tracked independently because the slave may accept them in
    // either order; bready only goes up once both have been taken.
    always_ff @(posedge aclk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mode      <= 1'b0;
            r_awaddr    <= 32'd0;
            r_awvalid   <= 1'b0;
            r_wdata     <= 32'd0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_araddr    <= 32'd0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_gap       <= 16'd0;
            r_rsp_valid <= 1'b0;
            r_result    <= 32'd0;
            r_err       <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_mode    <= req_mode;
                        r_awaddr  <= ADDR_INPUT;
                        r_wdata   <= req_theta;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= S_WR_IN;
                    end
                end
                S_WR_IN, S_WR_FLG: begin
                    if (w_b_hs) begin
                        r_bready  <= 1'b0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        if (bresp != 2'b00) begin
                            r_result    <= 32'd0;
                            r_err       <= 2'b01;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else if (r_state == S_WR_IN) begin
                            r_awaddr  <= ADDR_FLAGS_IN;
                            r_wdata   <= {29'd0, r_mode, 1'b1, 1'b0};
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WR_FLG;
                        end else begin
                            r_araddr  <= ADDR_FLAGS_OUT;
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_STAT;
                        end
                    end else begin
                        if (w_aw_hs) begin
                            r_awvalid <= 1'b0;
                            r_aw_done <= 1'b1;
                        end
                        if (w_w_hs) begin
                            r_wvalid <= 1'b0;
                            r_w_done <= 1'b1;
                        end
                        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                            r_bready <= 1'b1;
                        end
                    end
                end
                S_RD_STAT, S_RD_RES: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                    if (w_r_hs) begin
                        r_rready <= 1'b0;
                        if (rresp != 2'b00) begin
                            r_result    <= 32'd0;
                            r_err       <= 2'b01;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else if (r_state == S_RD_RES) begin
                            r_result    <= rdata;
                            r_err       <= 2'b00;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else if (rdata[0]) begin
                            // Done is clear-on-read, so this capture is final.
                            r_araddr  <= ADDR_RESULT;
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_RES;
                        end else if (w_timeout) begin
                            r_result    <= 32'd0;
                            r_err       <= 2'b10;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else if (POLL_GAP == 0) begin
                            r_arvalid <= 1'b1;
                        end else begin
                            r_gap   <= 16'd0;
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_LAST[15:0]) begin
                        r_arvalid <= 1'b1;
                        r_state   <= S_RD_STAT;
                    end else begin
                        r_gap <= r_gap + 16'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_result;
    assign rsp_err    = r_err;
    assign awaddr     = r_awaddr;
    assign awvalid    = r_awvalid;
    assign wdata      = r_wdata;
    assign wstrb      = 4'hF;
    assign wvalid     = r_wvalid;
    assign bready     = r_bready;
    assign araddr     = r_araddr;
    assign arvalid    = r_arvalid;
    assign rready     = r_rready;

endmodule
